latch_id_ex: RTL and testbench

- ID/EX pipeline register for the 5-stage MIPS core.
- Consumes the hazard unit's flushEX output and a hold request for future multicycle EX units.
- Produces the EX-stage operands and control signals that feed the hazard unit: rsEX, rtEX, writeRegEX, memToRegEX and regWriteEX.
- Tracks valid status and counts the bubbles it inserts, for performance debug.

---
 rtl/latch_id_ex_pkg.sv | 15 +
 rtl/latch_id_ex_if.sv | 35 +++
 rtl/latch_id_ex_sat_counter.sv | 13 +
 rtl/latch_id_ex.sv | 54 +++++
 tb/tb_latch_id_ex.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/latch_id_ex_pkg.sv
// latch_id_ex_pkg: widths and constants shared by the ID/EX pipeline latch.
package latch_id_ex_pkg;
   localparam int DATA_WIDTH     = 32;
   localparam int REG_ADDR_WIDTH = 5;
   localparam int ALU_CTRL_WIDTH = 3;
   localparam int CNT_WIDTH      = 16;

   localparam logic [ALU_CTRL_WIDTH-1:0] ALU_AND = 3'b000;
   localparam logic [ALU_CTRL_WIDTH-1:0] ALU_OR  = 3'b001;
   localparam logic [ALU_CTRL_WIDTH-1:0] ALU_ADD = 3'b010;
   localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SUB = 3'b110;
   localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SLT = 3'b111;

   localparam logic [REG_ADDR_WIDTH-1:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/latch_id_ex_if.sv
// latch_id_ex_if: decode-side inputs, EX-side outputs and hazard controls of the ID/EX latch.
interface latch_id_ex_if
   import latch_id_ex_pkg::*;
#(
   parameter int DW  = DATA_WIDTH,
   parameter int AW  = REG_ADDR_WIDTH,
   parameter int CW  = ALU_CTRL_WIDTH,
   parameter int NW  = CNT_WIDTH
) ();
   logic          flushEX, stallEX, validID;
   logic [AW-1:0] rsID, rtID, rdID;
   logic [DW-1:0] readData1ID, readData2ID, signImmID;
   logic          regWriteID, memToRegID, memWriteID, aluSrcID, regDstID;
   logic [CW-1:0] aluControlID;
   logic [AW-1:0] rsEX, rtEX, rdEX, writeRegEX;
   logic [DW-1:0] readData1EX, readData2EX, signImmEX;
   logic          regWriteEX, memToRegEX, memWriteEX, aluSrcEX, regDstEX;
   logic [CW-1:0] aluControlEX;
   logic          validEX;
   logic [NW-1:0] bubbleCount;

   modport master (
      output flushEX, stallEX, validID, rsID, rtID, rdID, readData1ID, readData2ID, signImmID,
             regWriteID, memToRegID, memWriteID, aluSrcID, regDstID, aluControlID,
      input  rsEX, rtEX, rdEX, writeRegEX, readData1EX, readData2EX, signImmEX,
             regWriteEX, memToRegEX, memWriteEX, aluSrcEX, regDstEX, aluControlEX, validEX, bubbleCount
   );

   modport slave (
      input  flushEX, stallEX, validID, rsID, rtID, rdID, readData1ID, readData2ID, signImmID,
             regWriteID, memToRegID, memWriteID, aluSrcID, regDstID, aluControlID,
      output rsEX, rtEX, rdEX, writeRegEX, readData1EX, readData2EX, signImmEX,
             regWriteEX, memToRegEX, memWriteEX, aluSrcEX, regDstEX, aluControlEX, validEX, bubbleCount
   );
endinterface

// File: rtl/latch_id_ex_sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 inc,
   output logic [CNT_WIDTH-1:0] count
);
   always_ff @(posedge clk or negedge reset)
      if (!reset) count <= '0;
      else if (inc && !(&count)) count <= count + 1'b1;
endmodule

// File: rtl/latch_id_ex.sv
// latch_id_ex: ID/EX pipeline register with flush (bubble), stall (hold) and bubble statistics.
module latch_id_ex #(
   parameter int DATA_WIDTH     = latch_id_ex_pkg::DATA_WIDTH,
   parameter int REG_ADDR_WIDTH = latch_id_ex_pkg::REG_ADDR_WIDTH,
   parameter int ALU_CTRL_WIDTH = latch_id_ex_pkg::ALU_CTRL_WIDTH,
   parameter int CNT_WIDTH      = latch_id_ex_pkg::CNT_WIDTH
) (
   input logic         clk,
   input logic         reset,
   latch_id_ex_if.slave bus
);
   import latch_id_ex_pkg::*;

   // A bubble zeroes rt and memToReg too, so the hazard unit's load-use check cannot fire on it.
   always_ff @(posedge clk or negedge reset)
      if (!reset || bus.flushEX) begin
         bus.rsEX         <= '0;
         bus.rtEX         <= '0;
         bus.rdEX         <= '0;
         bus.readData1EX  <= '0;
         bus.readData2EX  <= '0;
         bus.signImmEX    <= '0;
         bus.regWriteEX   <= 1'b0;
         bus.memToRegEX   <= 1'b0;
         bus.memWriteEX   <= 1'b0;
         bus.aluSrcEX     <= 1'b0;
         bus.regDstEX     <= 1'b0;
         bus.aluControlEX <= '0;
         bus.validEX      <= 1'b0;
      end else if (!bus.stallEX) begin
         bus.rsEX         <= bus.rsID;
         bus.rtEX         <= bus.rtID;
         bus.rdEX         <= bus.rdID;
         bus.readData1EX  <= bus.readData1ID;
         bus.readData2EX  <= bus.readData2ID;
         bus.signImmEX    <= bus.signImmID;
         bus.regWriteEX   <= bus.regWriteID;
         bus.memToRegEX   <= bus.memToRegID;
         bus.memWriteEX   <= bus.memWriteID;
         bus.aluSrcEX     <= bus.aluSrcID;
         bus.regDstEX     <= bus.regDstID;
         bus.aluControlEX <= bus.aluControlID;
         bus.validEX      <= bus.validID;
      end

   assign bus.writeRegEX = bus.regDstEX ? bus.rdEX : bus.rtEX;

   sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_bubbles (
      .clk   (clk),
      .reset (reset),
      .inc   (bus.flushEX),
      .count (bus.bubbleCount)
   );
endmodule

// File: tb/tb_latch_id_ex.sv
// tb_latch_id_ex: directed checks of load, flush, stall, async reset and bubble-count saturation.
module tb_latch_id_ex;
   import latch_id_ex_pkg::*;

   logic clk = 1'b0;
   logic reset;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   latch_id_ex_if #(.NW(4)) bus ();

   latch_id_ex #(.CNT_WIDTH(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_id();
      bus.flushEX = 0; bus.stallEX = 0; bus.validID = 0;
      bus.rsID = '0; bus.rtID = '0; bus.rdID = '0;
      bus.readData1ID = '0; bus.readData2ID = '0; bus.signImmID = '0;
      bus.regWriteID = 0; bus.memToRegID = 0; bus.memWriteID = 0; bus.aluSrcID = 0; bus.regDstID = 0;
      bus.aluControlID = '0;
   endtask

   initial begin
      reset = 1'b1;
      clear_id();
      #1 reset = 1'b0;
      #10;
      chk("reset_valid", bus.validEX, 0);
      chk("reset_count", bus.bubbleCount, 0);
      chk("reset_wreg", bus.writeRegEX, REG_ZERO);
      reset = 1'b1;

      // Load, bubble once, reload, then reset asynchronously mid-cycle.
      bus.rsID = 5; bus.regWriteID = 1; bus.validID = 1;
      tick();
      chk("pre_rs", bus.rsEX, 5);
      chk("pre_rw", bus.regWriteEX, 1);
      chk("pre_valid", bus.validEX, 1);
      bus.flushEX = 1;
      tick();
      chk("pre_count", bus.bubbleCount, 1);
      bus.flushEX = 0;
      tick();
      chk("reload_rs", bus.rsEX, 5);
      #2 reset = 1'b0;
      #1;
      chk("async_rs", bus.rsEX, 0);
      chk("async_rw", bus.regWriteEX, 0);
      chk("async_valid", bus.validEX, 0);
      chk("async_count", bus.bubbleCount, 0);
      tick();
      chk("held_rs", bus.rsEX, 0);
      chk("held_valid", bus.validEX, 0);
      reset = 1'b1;

      // Plain load; inputs must not reach EX before the edge.
      clear_id();
      bus.rsID = 3; bus.rtID = 4; bus.rdID = 7; bus.regDstID = 1;
      bus.readData1ID = 32'h0000_00AA; bus.aluControlID = ALU_ADD; bus.validID = 1;
      #1;
      chk("nocomb_rs", bus.rsEX, 0);
      chk("nocomb_wreg", bus.writeRegEX, 0);
      tick();
      chk("load_rs", bus.rsEX, 3);
      chk("load_rt", bus.rtEX, 4);
      chk("load_wreg", bus.writeRegEX, 7);
      chk("load_rd1", bus.readData1EX, 32'hAA);
      chk("load_alu", bus.aluControlEX, 3'b010);
      chk("load_valid", bus.validEX, 1);

      // lw in EX, then flush it.
      clear_id();
      bus.rtID = 8; bus.memToRegID = 1; bus.regWriteID = 1; bus.validID = 1; bus.readData1ID = 32'h10;
      tick();
      chk("lw_m2r", bus.memToRegEX, 1);
      chk("lw_wreg", bus.writeRegEX, 8);
      bus.flushEX = 1;
      tick();
      bus.flushEX = 0;
      chk("fl_m2r", bus.memToRegEX, 0);
      chk("fl_rt", bus.rtEX, 0);
      chk("fl_rw", bus.regWriteEX, 0);
      chk("fl_valid", bus.validEX, 0);
      chk("fl_wreg", bus.writeRegEX, 0);
      chk("fl_rd1", bus.readData1EX, 0);
      chk("fl_count", bus.bubbleCount, 1);

      // Stall for three edges while every ID input changes.
      clear_id();
      bus.rsID = 1; bus.rtID = 2; bus.rdID = 9; bus.regDstID = 1; bus.readData2ID = 32'h1234;
      bus.signImmID = 32'hFFFF_FFF0; bus.memWriteID = 1; bus.aluSrcID = 1; bus.aluControlID = ALU_SUB;
      bus.validID = 1;
      tick();
      chk("st_base_rd", bus.rdEX, 9);
      bus.stallEX = 1;
      for (int i = 0; i < 3; i++) begin
         bus.rsID = 5'(10 + i); bus.rtID = 5'(20 + i); bus.rdID = 5'(25 + i); bus.regDstID = 0;
         bus.readData2ID = 32'(i); bus.signImmID = 32'(i); bus.memWriteID = 0; bus.aluSrcID = 0;
         bus.aluControlID = ALU_OR; bus.validID = 0; bus.regWriteID = 1; bus.memToRegID = 1;
         bus.readData1ID = 32'hDEAD;
         tick();
         chk("st_rd", bus.rdEX, 9);
         chk("st_wreg", bus.writeRegEX, 9);
         chk("st_rd2", bus.readData2EX, 32'h1234);
         chk("st_imm", bus.signImmEX, 32'hFFFF_FFF0);
         chk("st_ctrl", {bus.memWriteEX, bus.aluSrcEX, bus.regWriteEX, bus.memToRegEX, bus.aluControlEX}, 7'b1100110);
         chk("st_valid", bus.validEX, 1);
         chk("st_count", bus.bubbleCount, 1);
      end
      bus.stallEX = 0;
      tick();
      chk("post_rs", bus.rsEX, 12);
      chk("post_wreg", bus.writeRegEX, 22);
      chk("post_rd2", bus.readData2EX, 2);
      chk("post_ctrl", {bus.memWriteEX, bus.aluSrcEX, bus.regWriteEX, bus.memToRegEX, bus.aluControlEX}, 7'b0011001);
      chk("post_valid", bus.validEX, 0);

      // Flush and stall together: flush wins.
      bus.validID = 1;
      tick();
      chk("pre_fs_valid", bus.validEX, 1);
      bus.flushEX = 1; bus.stallEX = 1;
      tick();
      chk("fs_valid", bus.validEX, 0);
      chk("fs_rt", bus.rtEX, 0);
      chk("fs_count", bus.bubbleCount, 2);

      // Back-to-back flushes saturate the 4-bit counter at 15.
      bus.stallEX = 0;
      for (int i = 1; i <= 20; i++) begin
         tick();
         chk("sat_count", bus.bubbleCount, (2 + i > 15) ? 15 : 2 + i);
      end
      bus.flushEX = 0;
      tick();
      chk("sat_hold", bus.bubbleCount, 15);
      chk("sat_load_valid", bus.validEX, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
